// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver, LSB first, mid-bit sampling.
//
// Parameters
//   CLKS_PER_BIT    rx_clk cycles per bit period. It must be even and >= 4.
//
// Ports
//   rx_clk          in   1  sole clock; all logic uses the rising edge
//   rx_reset        in   1  synchronous, active-high reset
//   rx_input        in   1  asynchronous serial line, idle high
//   rx_byte         out  8  last correctly framed byte (held until overwritten)
//   rx_valid        out  1  one-cycle pulse; rx_byte updates in the same cycle
//   rx_receiving    out  1  high while a frame is in progress
//   rx_frame_error  out  1  one-cycle pulse when the stop bit is sampled low
//
// The line passes through a two-flop synchronizer. Every FSM decision uses
// the synchronized value rx_s. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rx_clk,
  input  logic       rx_reset,
  input  logic       rx_input,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_receiving,
  output logic       rx_frame_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // START samples the start bit in the middle of the bit. Later samples are
  // one full bit period apart, so each one also lands mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            receiving_q, receiving_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s           = rx_s_q;
  assign rx_byte        = byte_q;
  assign rx_valid       = valid_q;
  assign rx_receiving   = receiving_q;
  assign rx_frame_error = ferr_q;

  // Next-state logic for the synchronizer, the receive FSM and the output flags.
  always_comb begin
    rx_meta_d = rx_input;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s == 1'b0) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s == 1'b0) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            // The line is high again at mid-bit, so treat the low pulse as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s == 1'b1) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            // On a bad stop bit, keep the old byte. Wait for the line to go
            // idle so that a break raises only one error.
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_HIGH: begin
        if (rx_s == 1'b1) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase

    // This flag looks ahead at the value rx_s takes next cycle. It therefore
    // rises in the same cycle that IDLE first sees the start edge. Otherwise
    // it follows "FSM not idle".
    if (state_d != IDLE) begin
      receiving_d = 1'b1;
    end else begin
      receiving_d = ~rx_meta_q;
    end
  end

  // State and output registers with synchronous reset; the synchronizer resets to idle-high.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
      receiving_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      receiving_q <= receiving_d;
      ferr_q      <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed testbench for uart_rx.
// Instance 0 uses CLKS_PER_BIT=16, instance 1 uses 4 and instance 2 uses 64.
// Line changes happen on the falling edge. If a line bit is driven starting
// at cycle k, the synchronized value rx_s shows it from cycle k+2 (T0).
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [2:0]      line = 3'b111;
  logic [2:0][7:0] rbyte;
  logic [2:0]      rvalid, rrecv, rferr;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .rx_clk(clk), .rx_reset(rst), .rx_input(line[0]),
    .rx_byte(rbyte[0]), .rx_valid(rvalid[0]), .rx_receiving(rrecv[0]), .rx_frame_error(rferr[0]));
  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .rx_clk(clk), .rx_reset(rst), .rx_input(line[1]),
    .rx_byte(rbyte[1]), .rx_valid(rvalid[1]), .rx_receiving(rrecv[1]), .rx_frame_error(rferr[1]));
  uart_rx #(.CLKS_PER_BIT(64)) dut64 (
    .rx_clk(clk), .rx_reset(rst), .rx_input(line[2]),
    .rx_byte(rbyte[2]), .rx_valid(rvalid[2]), .rx_receiving(rrecv[2]), .rx_frame_error(rferr[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse and flag recorder, sampled on the falling edge.
  int         vcnt [3] = '{0, 0, 0};
  int         fcnt [3] = '{0, 0, 0};
  int         vcyc [3] = '{0, 0, 0};
  int         fcyc [3] = '{0, 0, 0};
  int         rise [3] = '{0, 0, 0};
  int         fall [3] = '{0, 0, 0};
  logic [7:0] vbyte [3];
  int         werr = 0;
  int         oerr = 0;
  logic [2:0] pv = 3'b000, pf = 3'b000, pr = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rvalid[i] === 1'b1) begin
        vcnt[i]  <= vcnt[i] + 1;
        vcyc[i]  <= cyc;
        vbyte[i] <= rbyte[i];
      end
      if (rferr[i] === 1'b1) begin
        fcnt[i] <= fcnt[i] + 1;
        fcyc[i] <= cyc;
      end
      if (rrecv[i] === 1'b1 && pr[i] !== 1'b1) rise[i] <= cyc;
      if (rrecv[i] === 1'b0 && pr[i] === 1'b1) fall[i] <= cyc;
    end
    if (((rvalid & pv) | (rferr & pf)) !== 3'b000) werr <= werr + 1;
    if ((rvalid & rferr) !== 3'b000) oerr <= oerr + 1;
    pv <= rvalid;
    pf <= rferr;
    pr <= rrecv;
  end

  // Drives nbits line bits (start, data LSB first, stop). With glitch set,
  // the first 3 cycles of each data bit carry the inverted level.
  task automatic send_frame(input int i, input int cpb, input logic [7:0] data,
                            input logic stop_bit, input int nbits, input bit glitch,
                            output int k);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    k = cyc;
    for (int b = 0; b < nbits; b++) begin
      if (glitch && b >= 1 && b <= 8) begin
        line[i] = ~bits[b];
        repeat (3) @(negedge clk);
        line[i] = bits[b];
        repeat (cpb - 3) @(negedge clk);
      end else begin
        line[i] = bits[b];
        repeat (cpb) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    line = 3'b111;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rbyte[i] !== 8'h00) begin n_bad++; $display("FAIL reset_byte[%0d]: got %h expected 00", i, rbyte[i]); end
      n_cmp++; if (rvalid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, rvalid[i]); end
      n_cmp++; if (rrecv[i] !== 1'b0) begin n_bad++; $display("FAIL reset_recv[%0d]: got %b expected 0", i, rrecv[i]); end
      n_cmp++; if (rferr[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ferr[%0d]: got %b expected 0", i, rferr[i]); end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int k, v0, f0;
    v0 = vcnt[0]; f0 = fcnt[0];
    send_frame(0, 16, 8'hBE, 1'b1, 10, 1'b0, k);
    repeat (8) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0 + 1) begin n_bad++; $display("FAIL single_count: got %0d expected %0d", vcnt[0], v0 + 1); end
    n_cmp++; if (vcyc[0] !== k + 155) begin n_bad++; $display("FAIL single_cycle: got %0d expected %0d", vcyc[0], k + 155); end
    n_cmp++; if (vbyte[0] !== 8'hBE) begin n_bad++; $display("FAIL single_byte_at_valid: got %h expected be", vbyte[0]); end
    n_cmp++; if (rbyte[0] !== 8'hBE) begin n_bad++; $display("FAIL single_byte_held: got %h expected be", rbyte[0]); end
    n_cmp++; if (rise[0] !== k + 2) begin n_bad++; $display("FAIL single_recv_rise: got %0d expected %0d", rise[0], k + 2); end
    n_cmp++; if (fall[0] !== k + 155) begin n_bad++; $display("FAIL single_recv_fall: got %0d expected %0d", fall[0], k + 155); end
    n_cmp++; if (fcnt[0] !== f0) begin n_bad++; $display("FAIL single_no_ferr: got %0d expected %0d", fcnt[0], f0); end
  endtask

  task automatic test_glitch;
    int k, v0, f0;
    v0 = vcnt[0]; f0 = fcnt[0];
    k = cyc;
    line[0] = 1'b0;
    repeat (4) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0) begin n_bad++; $display("FAIL glitch_no_valid: got %0d expected %0d", vcnt[0], v0); end
    n_cmp++; if (fcnt[0] !== f0) begin n_bad++; $display("FAIL glitch_no_ferr: got %0d expected %0d", fcnt[0], f0); end
    n_cmp++; if (rbyte[0] !== 8'hBE) begin n_bad++; $display("FAIL glitch_byte: got %h expected be", rbyte[0]); end
    n_cmp++; if (rise[0] !== k + 2) begin n_bad++; $display("FAIL glitch_recv_rise: got %0d expected %0d", rise[0], k + 2); end
    n_cmp++; if (fall[0] !== k + 11) begin n_bad++; $display("FAIL glitch_recv_fall: got %0d expected %0d", fall[0], k + 11); end
  endtask

  task automatic test_frame_error;
    int k, v0, f0;
    v0 = vcnt[0]; f0 = fcnt[0];
    send_frame(0, 16, 8'h55, 1'b0, 10, 1'b0, k);
    repeat (40) @(negedge clk);
    line[0] = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (fcnt[0] !== f0 + 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected %0d", fcnt[0], f0 + 1); end
    n_cmp++; if (fcyc[0] !== k + 155) begin n_bad++; $display("FAIL ferr_cycle: got %0d expected %0d", fcyc[0], k + 155); end
    n_cmp++; if (vcnt[0] !== v0) begin n_bad++; $display("FAIL ferr_no_valid: got %0d expected %0d", vcnt[0], v0); end
    n_cmp++; if (rbyte[0] !== 8'hBE) begin n_bad++; $display("FAIL ferr_byte: got %h expected be", rbyte[0]); end
    n_cmp++; if (rise[0] !== k + 2) begin n_bad++; $display("FAIL ferr_recv_rise: got %0d expected %0d", rise[0], k + 2); end
    n_cmp++; if (fall[0] !== k + 203) begin n_bad++; $display("FAIL ferr_recv_fall: got %0d expected %0d", fall[0], k + 203); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [3];
    int k, v0;
    int vc [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hA5;
    v0 = vcnt[0];
    for (int j = 0; j < 3; j++) begin
      send_frame(0, 16, pat[j], 1'b1, 10, 1'b0, k);
      vc[j] = vcyc[0];
      n_cmp++; if (vcyc[0] !== k + 155) begin n_bad++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", j, vcyc[0], k + 155); end
      n_cmp++; if (vbyte[0] !== pat[j]) begin n_bad++; $display("FAIL b2b_byte[%0d]: got %h expected %h", j, vbyte[0], pat[j]); end
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0 + 3) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", vcnt[0], v0 + 3); end
    n_cmp++; if (vc[1] - vc[0] !== 160) begin n_bad++; $display("FAIL b2b_spacing01: got %0d expected 160", vc[1] - vc[0]); end
    n_cmp++; if (vc[2] - vc[1] !== 160) begin n_bad++; $display("FAIL b2b_spacing12: got %0d expected 160", vc[2] - vc[1]); end
  endtask

  task automatic test_data_glitch;
    int k, v0;
    v0 = vcnt[0];
    send_frame(0, 16, 8'h5A, 1'b1, 10, 1'b1, k);
    repeat (8) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0 + 1) begin n_bad++; $display("FAIL dglitch_count: got %0d expected %0d", vcnt[0], v0 + 1); end
    n_cmp++; if (vcyc[0] !== k + 155) begin n_bad++; $display("FAIL dglitch_cycle: got %0d expected %0d", vcyc[0], k + 155); end
    n_cmp++; if (rbyte[0] !== 8'h5A) begin n_bad++; $display("FAIL dglitch_byte: got %h expected 5a", rbyte[0]); end
  endtask

  task automatic test_reset_mid_frame;
    int k, v0, f0;
    v0 = vcnt[0]; f0 = fcnt[0];
    // Send start and data bits 0..3 of 0x3C, then two cycles into data bit 4.
    send_frame(0, 16, 8'h3C, 1'b1, 5, 1'b0, k);
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rbyte[0] !== 8'h00) begin n_bad++; $display("FAIL midrst_byte: got %h expected 00", rbyte[0]); end
    n_cmp++; if (rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", rvalid[0]); end
    n_cmp++; if (rrecv[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_recv: got %b expected 0", rrecv[0]); end
    n_cmp++; if (rferr[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_ferr: got %b expected 0", rferr[0]); end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d expected %0d", vcnt[0], v0); end
    n_cmp++; if (fcnt[0] !== f0) begin n_bad++; $display("FAIL midrst_no_ferr: got %0d expected %0d", fcnt[0], f0); end
    send_frame(0, 16, 8'hC3, 1'b1, 10, 1'b0, k);
    repeat (8) @(negedge clk);
    n_cmp++; if (vcnt[0] !== v0 + 1) begin n_bad++; $display("FAIL midrst_next_count: got %0d expected %0d", vcnt[0], v0 + 1); end
    n_cmp++; if (vcyc[0] !== k + 155) begin n_bad++; $display("FAIL midrst_next_cycle: got %0d expected %0d", vcyc[0], k + 155); end
    n_cmp++; if (rbyte[0] !== 8'hC3) begin n_bad++; $display("FAIL midrst_next_byte: got %h expected c3", rbyte[0]); end
  endtask

  task automatic test_param_sweep;
    int k, cpb, exp_cyc;
    for (int i = 1; i < 3; i++) begin
      cpb = (i == 1) ? 4 : 64;
      send_frame(i, cpb, 8'h81, 1'b1, 10, 1'b0, k);
      repeat (8) @(negedge clk);
      exp_cyc = k + 2 + cpb / 2 + 9 * cpb + 1;
      n_cmp++; if (vcnt[i] !== 1) begin n_bad++; $display("FAIL sweep%0d_count: got %0d expected 1", cpb, vcnt[i]); end
      n_cmp++; if (vcyc[i] !== exp_cyc) begin n_bad++; $display("FAIL sweep%0d_cycle: got %0d expected %0d", cpb, vcyc[i], exp_cyc); end
      n_cmp++; if (rbyte[i] !== 8'h81) begin n_bad++; $display("FAIL sweep%0d_byte: got %h expected 81", cpb, rbyte[i]); end
      n_cmp++; if (fcnt[i] !== 0) begin n_bad++; $display("FAIL sweep%0d_no_ferr: got %0d expected 0", cpb, fcnt[i]); end
    end
  endtask

  task automatic test_pulse_rules;
    n_cmp++; if (werr !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d long pulses expected 0", werr); end
    n_cmp++; if (oerr !== 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d overlaps expected 0", oerr); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_data_glitch();
    test_reset_mid_frame();
    test_param_sweep();
    test_pulse_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface

Parameters:
- REQ-001: CLKS_PER_BIT, default 16. Meaning: rx_clk cycles per bit period; SHALL be even and >= 4.

Ports (name, direction, width, meaning):
- REQ-002: rx_clk, input, 1. Sole clock; all logic on the rising edge.
- REQ-003: rx_reset, input, 1. Reset; synchronous, active-high.
- REQ-004: rx_input, input, 1. Asynchronous serial line; idle high; 8N1 framing, LSB first.
- REQ-005: rx_byte, output, 8. Last correctly framed byte received.
- REQ-006: rx_valid, output, 1. One-cycle pulse; rx_byte updated in that same cycle.
- REQ-007: rx_receiving, output, 1. High while a frame is in progress (any state except IDLE).
- REQ-008: rx_frame_error, output, 1. One-cycle pulse when the stop bit is sampled low.

Function
- REQ-009: rx_input SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s). No other logic reads the raw rx_input.
- REQ-010: FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH. The bit-period counter is cnt, width clog2(CLKS_PER_BIT); the bit index is idx, 3 bits.
- REQ-011: IDLE: rx_s == 0 -> START with cnt = 0. Otherwise stay in IDLE. Call this cycle T0.
- REQ-012: START: cnt increments each cycle. At cnt == CLKS_PER_BIT/2-1, sample rx_s:
  - rx_s == 0 -> DATA with cnt = 0, idx = 0.
  - rx_s == 1 -> IDLE (glitch rejected); no output pulse.
- REQ-013: DATA: at cnt == CLKS_PER_BIT-1, sample rx_s into shift register bit idx (LSB first) and clear cnt.
  - idx == 7 -> STOP with cnt = 0.
  - Otherwise idx + 1.
- REQ-014: STOP: at cnt == CLKS_PER_BIT-1, sample rx_s:
  - rx_s == 1 -> rx_byte <= shift register, rx_valid = 1 for the next cycle only, then IDLE.
  - rx_s == 0 -> rx_frame_error = 1 for the next cycle only, rx_byte unchanged, then WAIT_HIGH.
- REQ-015: WAIT_HIGH: stay until rx_s == 1, then IDLE. A line held low (break) SHALL produce exactly one rx_frame_error and no rx_valid.
- REQ-016: Latency: rx_valid SHALL be high exactly in cycle T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1. rx_byte SHALL be stable from that cycle until the next rx_valid or reset.
- REQ-017: rx_valid and rx_frame_error SHALL never be high in the same cycle. Neither pulse SHALL exceed one cycle.
- REQ-018: A new start bit (rx_s low) in the first IDLE cycle after STOP SHALL be accepted. Back-to-back frames with no idle gap SHALL all be received.
- REQ-019: There is no consumer handshake. An unread rx_byte is overwritten by the next valid frame, with no overrun indication.
- REQ-020: rx_input changes during DATA between sample points SHALL have no effect. Only one sample per bit is taken, at mid-bit.

Reset
- REQ-021: While rx_reset == 1 at a clock edge, the block SHALL go to IDLE, and SHALL clear cnt, idx, the shift register and the synchronizer flops. The synchronizer flops reset to 1 (idle line).
- REQ-022: Output reset values: rx_byte = 8'h00, rx_valid = 0, rx_receiving = 0, rx_frame_error = 0.
- REQ-023: Reset asserted mid-frame SHALL abort the frame with no pulse on either output. After release, the block SHALL resynchronize on the next falling edge of rx_s.

Verification (CLKS_PER_BIT = 16 unless stated)
- REQ-024: Single frame. Reset, then drive 8N1 frame 0xBE (line bits 0,0,1,1,1,1,1,0,1,1) -> one rx_valid pulse with rx_byte = 8'hBE, at T0 + 153; rx_receiving high from T0 to T0 + 152.
- REQ-025: Glitch. A low pulse of 4 cycles on idle line -> return to IDLE, no rx_valid, no rx_frame_error, rx_byte unchanged.
- REQ-026: Framing error. Frame 0x55 with stop bit low, line held low 40 more cycles, then high -> one rx_frame_error pulse, no rx_valid, rx_byte unchanged. rx_receiving stays high until the cycle after rx_s returns high.
- REQ-027: Back-to-back. Frames 0x00, 0xFF, 0xA5 with no idle gap -> three rx_valid pulses exactly 160 cycles apart, with rx_byte 00, FF, A5.
- REQ-028: Reset mid-frame. rx_reset pulsed during DATA idx = 4 of 0x3C -> no pulse, outputs at reset values. A following frame 0xC3 is received correctly.
- REQ-029: Parameter sweep. CLKS_PER_BIT = 4 and CLKS_PER_BIT = 64 with frame 0x81 -> rx_byte = 8'h81 at the REQ-016 cycle for each value.
